// File: rtl/square_mover_pkg.sv
// Shared geometry, bus layout and state encoding for the square mover.
// Also holds the per-axis step helpers used by the sweep datapath.
package square_mover_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SQUARE_SIZE = 30;

  localparam int SLOT_W     = 40;
  localparam int NUM_SLOTS  = 16;
  localparam int PLAYER_OFS = 640;
  localparam int POS_W      = 660;
  localparam int COORD_W    = 10;
  localparam int LFSR_W     = 16;

  localparam logic [9:0] PARK_COORD = 10'd1023;

  localparam int X_OFS    = 0;
  localparam int Y_OFS    = 10;
  localparam int ACT_OFS  = 20;
  localparam int XDIR_OFS = 21;
  localparam int YDIR_OFS = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Enemy axis step; returns {new_dir, new_coord}. Bounces clamp onto the edge.
  function automatic logic [10:0] enemy_axis(input logic [9:0]  coord,
                                             input logic        dir,
                                             input logic [10:0] lim,
                                             input logic [10:0] spd);
    logic [10:0] c11;
    logic [10:0] sum;
    logic [10:0] diff;
    c11  = {1'b0, coord};
    sum  = c11 + spd;
    diff = c11 - spd;
    if (!dir) begin
      if (sum > lim) return {1'b1, lim[9:0]};
      return {1'b0, sum[9:0]};
    end
    if (c11 < spd) return {1'b0, 10'd0};
    return {1'b1, diff[9:0]};
  endfunction

  function automatic logic [9:0] player_axis(input logic [9:0]  coord,
                                             input logic        dec,
                                             input logic        inc,
                                             input logic [10:0] lim,
                                             input logic [10:0] spd);
    logic [10:0] c11;
    logic [10:0] sum;
    logic [10:0] diff;
    c11  = {1'b0, coord};
    sum  = c11 + spd;
    diff = c11 - spd;
    if (dec && !inc) return (c11 < spd) ? 10'd0 : diff[9:0];
    if (inc && !dec) return (sum > lim) ? lim[9:0] : sum[9:0];
    return coord;
  endfunction

endpackage

// File: rtl/square_mover_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for enemy spawns.
module square_lfsr
  import square_mover_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end
  end

endmodule

// File: rtl/square_mover.sv
// Owns the player and 16 enemy squares; sweeps one slot per clk after each
// refresh tick and publishes the packed position bus for the collision checker.
module square_mover #(
  parameter int          SQUARE_SIZE  = 30,
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          ENEMY_SPEED  = 2,
  parameter int          PLAYER_SPEED = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                refresh_tick,
  input  logic                                start,
  input  logic                                btn_left,
  input  logic                                btn_right,
  input  logic                                btn_up,
  input  logic                                btn_down,
  input  logic                                status,
  input  logic [5:0]                          num_squares,
  output logic [square_mover_pkg::POS_W-1:0]  position,
  output logic                                busy,
  output logic                                game_over
);

  import square_mover_pkg::*;

  localparam logic [10:0] X_LIM      = 11'(H_ACTIVE - SQUARE_SIZE);
  localparam logic [10:0] Y_LIM      = 11'(V_ACTIVE - SQUARE_SIZE);
  localparam logic [10:0] E_SPD      = 11'(ENEMY_SPEED);
  localparam logic [10:0] P_SPD      = 11'(PLAYER_SPEED);
  localparam logic [9:0]  PLAYER_X0  = 10'((H_ACTIVE - SQUARE_SIZE) / 2);
  localparam logic [9:0]  PLAYER_Y0  = 10'((V_ACTIVE - SQUARE_SIZE) / 2);
  localparam logic [4:0]  PLAYER_IDX = 5'(NUM_SLOTS);

  state_t state, state_next;

  logic [LFSR_W-1:0]    lfsr;
  logic [9:0]           ex [NUM_SLOTS];
  logic [9:0]           ey [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] eact, exd, eyd;
  logic [9:0]           px, py;
  logic [4:0]           idx;
  logic [3:0]           btn_q;

  logic       collide, sweep_launch, layout_restore;
  logic [3:0] slot;
  logic [4:0] active_limit;
  logic [9:0] nx, ny;
  logic       nxd, nyd, nact;

  square_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  assign collide        = (state == RUN) && refresh_tick && !status;
  assign sweep_launch   = (state == RUN) && refresh_tick && status && !busy;
  assign layout_restore = (state == OVER) && start;
  assign game_over      = (state == OVER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (collide) state_next = OVER;
      OVER:    if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next value of the enemy slot addressed by the sweep index.
  always_comb begin
    slot         = idx[3:0];
    active_limit = (num_squares > 6'd16) ? 5'd16 : num_squares[4:0];
    nx   = ex[slot];
    ny   = ey[slot];
    nxd  = exd[slot];
    nyd  = eyd[slot];
    nact = eact[slot];
    if (eact[slot]) begin
      {nxd, nx} = enemy_axis(ex[slot], exd[slot], X_LIM, E_SPD);
      {nyd, ny} = enemy_axis(ey[slot], eyd[slot], Y_LIM, E_SPD);
    end else if ({1'b0, slot} < active_limit) begin
      nx   = {1'b0, lfsr[8:0]};
      ny   = {2'b0, lfsr[15:8]};
      nxd  = lfsr[3];
      nyd  = lfsr[6];
      nact = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || layout_restore) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ex[i] <= PARK_COORD;
        ey[i] <= PARK_COORD;
      end
      eact  <= '0;
      exd   <= '0;
      eyd   <= '0;
      px    <= PLAYER_X0;
      py    <= PLAYER_Y0;
      busy  <= 1'b0;
      idx   <= '0;
      btn_q <= '0;
    end else if (collide) begin
      busy <= 1'b0;
    end else if (sweep_launch) begin
      busy  <= 1'b1;
      idx   <= '0;
      btn_q <= {btn_left, btn_right, btn_up, btn_down};
    end else if (busy) begin
      if (idx == PLAYER_IDX) begin
        px   <= player_axis(px, btn_q[3], btn_q[2], X_LIM, P_SPD);
        py   <= player_axis(py, btn_q[1], btn_q[0], Y_LIM, P_SPD);
        busy <= 1'b0;
      end else begin
        ex[slot]   <= nx;
        ey[slot]   <= ny;
        exd[slot]  <= nxd;
        eyd[slot]  <= nyd;
        eact[slot] <= nact;
      end
      idx <= idx + 5'd1;
    end
  end

  always_comb begin
    position = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      position[i*SLOT_W + X_OFS +: COORD_W] = ex[i];
      position[i*SLOT_W + Y_OFS +: COORD_W] = ey[i];
      position[i*SLOT_W + ACT_OFS]          = eact[i];
      position[i*SLOT_W + XDIR_OFS]         = exd[i];
      position[i*SLOT_W + YDIR_OFS]         = eyd[i];
    end
    position[PLAYER_OFS +: COORD_W]           = px;
    position[PLAYER_OFS + COORD_W +: COORD_W] = py;
  end

endmodule

// File: tb/tb_square_mover.sv
// Scoreboard bench for square_mover: a game-level model predicts the bus after
// each sweep, and a monitor compares whenever busy falls.
module tb_square_mover;

  logic         clk = 1'b0;
  logic         reset;
  logic         refresh_tick, start, status;
  logic         btn_left, btn_right, btn_up, btn_down;
  logic [5:0]   num_squares;
  logic [659:0] position;
  logic         busy, game_over;

  square_mover dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .start        (start),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .status       (status),
    .num_squares  (num_squares),
    .position     (position),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int           m_x [16];
  int           m_y [16];
  bit           m_act [16];
  bit           m_xd [16];
  bit           m_yd [16];
  int           m_px, m_py;
  int           m_mode;
  bit           m_busy;
  logic [15:0]  m_lfsr;
  logic [659:0] exp_q [$];

  int compared = 0;
  int mismatched = 0;
  int sweeps_issued = 0;
  int sweeps_seen = 0;
  int busy_len = 0;
  bit prev_busy = 1'b0;
  bit ignore_drop = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lfsr_next(m_lfsr);

  task automatic checkOutput(input string name, input logic [659:0] act, input logic [659:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [659:0] build_expected();
    logic [659:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      p[i*40 +: 10]      = 10'(m_x[i]);
      p[i*40 + 10 +: 10] = 10'(m_y[i]);
      p[i*40 + 20]       = m_act[i];
      p[i*40 + 21]       = m_xd[i];
      p[i*40 + 22]       = m_yd[i];
    end
    p[649:640] = 10'(m_px);
    p[659:650] = 10'(m_py);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_x[i] = 1023; m_y[i] = 1023;
      m_act[i] = 0; m_xd[i] = 0; m_yd[i] = 0;
    end
    m_px = 305;
    m_py = 225;
  endtask

  task automatic move_axis(inout int c, inout bit d, input int lim);
    if (!d) begin
      if (c + 2 > lim) begin c = lim; d = 1; end
      else c = c + 2;
    end else begin
      if (c < 2) begin c = 0; d = 0; end
      else c = c - 2;
    end
  endtask

  task automatic model_sweep(input logic [3:0] b);
    logic [15:0] l;
    int n;
    l = m_lfsr;
    n = (num_squares > 16) ? 16 : int'(num_squares);
    for (int i = 0; i < 16; i++) begin
      l = lfsr_next(l);
      if (m_act[i]) begin
        move_axis(m_x[i], m_xd[i], 610);
        move_axis(m_y[i], m_yd[i], 450);
      end else if (i < n) begin
        m_x[i] = int'(l[8:0]);
        m_y[i] = int'(l[15:8]);
        m_xd[i] = l[3];
        m_yd[i] = l[6];
        m_act[i] = 1;
      end
    end
    if (b[3] && !b[2]) m_px = (m_px < 4) ? 0 : m_px - 4;
    if (b[2] && !b[3]) m_px = (m_px + 4 > 610) ? 610 : m_px + 4;
    if (b[1] && !b[0]) m_py = (m_py < 4) ? 0 : m_py - 4;
    if (b[0] && !b[1]) m_py = (m_py + 4 > 450) ? 450 : m_py + 4;
  endtask

  // b = {left, right, up, down}; mode 0 = idle, 1 = run, 2 = over
  task automatic applyStimulus(input bit do_tick, input bit do_start, input logic [3:0] b);
    @(negedge clk);
    {btn_left, btn_right, btn_up, btn_down} = b;
    refresh_tick = do_tick;
    start = do_start;
    if (do_start) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 2) begin model_reset(); m_mode = 0; end
    end
    if (do_tick && m_mode == 1) begin
      if (!status) begin
        m_mode = 2;
      end else if (!m_busy) begin
        model_sweep(b);
        exp_q.push_back(build_expected());
        sweeps_issued++;
        m_busy = 1;
      end
    end
    @(negedge clk);
    refresh_tick = 0;
    start = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sweeps_seen < sweeps_issued && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sweeps_seen < sweeps_issued) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL sweep_timeout: seen %0d want %0d", sweeps_seen, sweeps_issued);
      sweeps_seen = sweeps_issued;
      exp_q.delete();
    end
    m_busy = 0;
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_len++;
    end else if (prev_busy) begin
      if (ignore_drop) begin
        ignore_drop = 0;
      end else if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL sweep_unexpected: busy fell with no sweep pending");
      end else begin
        sweeps_seen++;
        checkOutput("busy_len", 660'(busy_len), 660'(17));
        checkOutput("sweep_pos", position, exp_q.pop_front());
      end
      busy_len = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1; refresh_tick = 0; start = 0; status = 1;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    num_squares = 6'd2;
    m_mode = 0; m_busy = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checkOutput("reset_pos", position, build_expected());
    checkOutput("reset_busy", 660'(busy), 660'(0));
    checkOutput("reset_game_over", 660'(game_over), 660'(0));

    for (int t = 0; t < 5; t++) applyStimulus(1, 0, 4'(t));
    repeat (20) @(negedge clk);
    checkOutput("idle_frozen", position, build_expected());
    checkOutput("idle_busy", 660'(busy), 660'(0));

    applyStimulus(0, 1, 4'b0000);
    applyStimulus(1, 0, 4'b0000);
    wait_idle();

    for (int t = 0; t < 20; t++) begin
      num_squares = 6'($urandom_range(0, 40));
      applyStimulus(1, 0, 4'($urandom_range(0, 15)));
      wait_idle();
    end

    applyStimulus(1, 0, 4'b0100);
    repeat (4) @(negedge clk);
    applyStimulus(1, 0, 4'b1000);
    wait_idle();
    repeat (25) @(negedge clk);
    checkOutput("single_sweep", 660'(sweeps_seen), 660'(sweeps_issued));

    num_squares = 6'd16;
    for (int t = 0; t < 80; t++) begin applyStimulus(1, 0, 4'b1010); wait_idle(); end
    for (int t = 0; t < 152; t++) begin applyStimulus(1, 0, 4'b0100); wait_idle(); end
    applyStimulus(1, 0, 4'b0111);
    wait_idle();
    checkOutput("player_clamp_x", 660'(position[649:640]), 660'(610));
    checkOutput("player_hold_y", 660'(position[659:650]), 660'(0));

    status = 0;
    applyStimulus(1, 0, 4'b0000);
    status = 1;
    repeat (2) @(negedge clk);
    checkOutput("over_flag", 660'(game_over), 660'(1));
    checkOutput("over_busy", 660'(busy), 660'(0));
    for (int t = 0; t < 3; t++) begin
      applyStimulus(1, 0, 4'b0110);
      repeat (20) @(negedge clk);
      checkOutput("over_frozen", position, build_expected());
    end
    applyStimulus(0, 1, 4'b0000);
    checkOutput("restart_layout", position, build_expected());
    checkOutput("restart_game_over", 660'(game_over), 660'(0));

    applyStimulus(0, 1, 4'b0000);
    num_squares = 6'd3;
    applyStimulus(1, 0, 4'b0001);
    wait_idle();

    applyStimulus(1, 0, 4'b0100);
    repeat (7) @(negedge clk);
    reset = 1;
    ignore_drop = 1;
    exp_q.delete();
    sweeps_issued--;
    m_busy = 0;
    model_reset();
    m_mode = 0;
    @(negedge clk);
    reset = 0;
    checkOutput("midsweep_reset_pos", position, build_expected());
    checkOutput("midsweep_reset_busy", 660'(busy), 660'(0));
    checkOutput("midsweep_reset_over", 660'(game_over), 660'(0));

    repeat (30) @(negedge clk);
    checkOutput("queue_drained", 660'(exp_q.size()), 660'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/square_mover.md
Name: square_mover

Overview:
- Producer of the packed 660-bit square-position bus read by the collision/score checker.
- Owns the player square and 16 enemy squares.
- On each refresh_tick it sweeps all slots sequentially: moves, bounces and spawns enemies, and moves the player from buttons.
- Consumes the checker's status (0 = collision) and num_squares (enemy count); runs the game IDLE/RUN/OVER state machine.

Parameters:
SQUARE_SIZE, 30, square edge in pixels
H_ACTIVE, 640, visible width
V_ACTIVE, 480, visible height
ENEMY_SPEED, 2, enemy pixels per axis per refresh
PLAYER_SPEED, 4, player pixels per refresh
LFSR_SEED, 16'hACE1, spawn LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
refresh_tick  in  1  one-clk pulse per frame
start  in  1  one-clk pulse; IDLE->RUN, OVER->IDLE
btn_left/btn_right/btn_up/btn_down  in  1 each  debounced player buttons
status  in  1  checker result; 0 = collision
num_squares  in  6  requested active enemy count; values >16 treated as 16
position  out  660  slot i (0..15) at [i*40+39:i*40]: [9:0] x, [19:10] y, [20] active, [21] xdir (1 = negative), [22] ydir, [39:23] zero; player x at [649:640], y at [659:650]
busy  out  1  sweep in progress
game_over  out  1  high in OVER

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - Every enemy slot parked: x = y = 1023, flags 0. Parking makes the checker's strict compares fail, so no collision is possible.
  - Player at (305,225); busy = 0; game_over = 0; state IDLE; LFSR = LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk in all states.
- States:
  - IDLE: start -> RUN.
  - RUN: refresh_tick while not busy launches a sweep. On refresh_tick, status==0 -> OVER; no sweep on that tick.
  - OVER: position frozen, game_over = 1. start -> IDLE with the reset layout restored in one clk; LFSR is not reseeded.
- Sweep:
  - Starts the clk after refresh_tick; busy = 1 for exactly 17 clks.
  - Index 0..15 = enemy slots, one per clk; index 16 = player.
  - busy drops the clk after index 16.
  - refresh_tick while busy is ignored.
  - Buttons are latched at refresh_tick.
- Enemy slot i:
  - i >= min(num_squares,16) and inactive: unchanged.
  - i < N and inactive (spawn): x = {1'b0,lfsr[8:0]}, y = {2'b0,lfsr[15:8]}, xdir = lfsr[3], ydir = lfsr[6], active = 1. A slot does not move on its spawn sweep.
  - Active: per axis, dir 0: if coord + ENEMY_SPEED > H_ACTIVE-SQUARE_SIZE (610; 450 for y), clamp to 610/450 and set dir 1, else add. Dir 1: if coord < ENEMY_SPEED, set 0 and dir 0, else subtract.
  - Spawn x max 511 and y max 255, so a spawn is always in range.
  - Active slots never deactivate except by reset or OVER->IDLE.
- Player:
  - left/right move x by PLAYER_SPEED; up/down move y.
  - Clamped to [0,610] x and [0,450] y.
  - Opposing buttons both high: no motion on that axis.
- All arithmetic is 11-bit internally to avoid wrap; results are 10-bit.
- Reset mid-sweep: all reset values on the next clk; the sweep is abandoned.

Decomposition:
- Shared package holds: H_ACTIVE, V_ACTIVE, SQUARE_SIZE, SLOT_W = 40, NUM_SLOTS = 16, PLAYER_OFS = 640, PARK_COORD = 1023, field offsets for x/y/active/xdir/ydir, and the state encoding IDLE/RUN/OVER.
- One sub-module: square_lfsr (seeded 16-bit LFSR, synchronous reset, free-running).

Test Plan:
- Reset -> all slots x = y = 1023, player (305,225), busy 0, game_over 0; 5 ticks in IDLE leave position unchanged.
- start, num_squares=2, tick -> busy high 17 clks; slots 0,1 active at LFSR-derived coords; slots 2..15 stay parked.
- Slot 0 at x=609, xdir 0, next tick -> x=610, xdir 1; at x=1, xdir 1 -> x=0, xdir 0.
- Player at (608,0), btn_right + btn_up + btn_down held, tick -> player (610,0), y unchanged.
- status=0 at tick in RUN -> game_over 1, next 3 ticks position frozen; start -> IDLE layout restored, game_over 0.
- Tick during busy ignored (exactly one sweep); reset asserted at sweep index 7 -> reset layout next clk, busy 0.
